l2_req_arbiter: RTL and testbench

- Shares the single next-level (L2) request port between the instruction-cache and data-cache miss/write-through address outputs.
- Latches one 26-bit line address per transaction and sequences the L2 handshake.
- Uses round-robin arbitration on contention.
- Keeps per-source grant counts and a contention count for the statistics module.

---
 rtl/l2_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_l2_req_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares the single L2 request port between the I-cache and
// D-cache miss paths with round-robin arbitration and grant statistics.
module l2_req_arbiter #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_we,
  output logic              dc_gnt,
  output logic              l2_valid,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_we,
  output logic              l2_src,
  input  logic              l2_ready,
  input  logic              l2_done,
  output logic              busy,
  output logic [CNT_W-1:0]  ic_cnt,
  output logic [CNT_W-1:0]  dc_cnt,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              timeout_err
);

  // Timer only has to hold 0..TIMEOUT-1.
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               hold, hold_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               last_src, last_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               we_nxt, src_nxt;
  logic               ic_gnt_nxt, dc_gnt_nxt;
  logic [CNT_W-1:0]   ic_cnt_nxt, dc_cnt_nxt, conflict_nxt;
  logic               terr_nxt;
  logic               pick_ic, pick_dc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, arbitration and statistics update.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = 1'b0;
    timer_nxt    = timer;
    last_nxt     = last_src;
    addr_nxt     = l2_addr;
    we_nxt       = l2_we;
    src_nxt      = l2_src;
    ic_gnt_nxt   = 1'b0;
    dc_gnt_nxt   = 1'b0;
    ic_cnt_nxt   = ic_cnt;
    dc_cnt_nxt   = dc_cnt;
    conflict_nxt = conflict_cnt;
    terr_nxt     = timeout_err;
    pick_ic      = 1'b0;
    pick_dc      = 1'b0;

    case (state)
      ST_IDLE: begin
        // The first IDLE cycle after a transaction never grants.
        if (!hold) begin
          if (ic_req && dc_req) begin
            conflict_nxt = sat_inc(conflict_cnt);
            pick_ic      = last_src;
            pick_dc      = !last_src;
          end else begin
            pick_ic = ic_req;
            pick_dc = dc_req;
          end
        end
        if (pick_ic) begin
          addr_nxt   = ic_addr;
          we_nxt     = 1'b0;
          src_nxt    = 1'b0;
          last_nxt   = 1'b0;
          ic_gnt_nxt = 1'b1;
          ic_cnt_nxt = sat_inc(ic_cnt);
          state_nxt  = ST_ISSUE;
        end else if (pick_dc) begin
          addr_nxt   = dc_addr;
          we_nxt     = dc_we;
          src_nxt    = 1'b1;
          last_nxt   = 1'b1;
          dc_gnt_nxt = 1'b1;
          dc_cnt_nxt = sat_inc(dc_cnt);
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (l2_ready) begin
          if (l2_done) begin
            state_nxt = ST_IDLE;
            hold_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            timer_nxt = '0;
          end
        end
      end
      ST_WAIT: begin
        if (l2_done) begin
          state_nxt = ST_IDLE;
          hold_nxt  = 1'b1;
        end else if ((TIMEOUT != 0) && ((32'(timer) + 32'd1) == 32'(TIMEOUT))) begin
          terr_nxt  = 1'b1;
          state_nxt = ST_IDLE;
          hold_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hold         <= 1'b0;
      timer        <= '0;
      last_src     <= 1'b1;
      l2_addr      <= '0;
      l2_we        <= 1'b0;
      l2_src       <= 1'b0;
      l2_valid     <= 1'b0;
      busy         <= 1'b0;
      ic_gnt       <= 1'b0;
      dc_gnt       <= 1'b0;
      ic_cnt       <= '0;
      dc_cnt       <= '0;
      conflict_cnt <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold         <= hold_nxt;
      timer        <= timer_nxt;
      last_src     <= last_nxt;
      l2_addr      <= addr_nxt;
      l2_we        <= we_nxt;
      l2_src       <= src_nxt;
      l2_valid     <= (state_nxt == ST_ISSUE);
      busy         <= (state_nxt != ST_IDLE);
      ic_gnt       <= ic_gnt_nxt;
      dc_gnt       <= dc_gnt_nxt;
      ic_cnt       <= ic_cnt_nxt;
      dc_cnt       <= dc_cnt_nxt;
      conflict_cnt <= conflict_nxt;
      timeout_err  <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed testbench for l2_req_arbiter (CNT_W = 4, TIMEOUT = 4).
module tb_l2_req_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned CW = 4;

  logic          clk, rst_n;
  logic          ic_req, dc_req, dc_we, l2_ready, l2_done;
  logic [AW-1:0] ic_addr, dc_addr;
  logic          ic_gnt, dc_gnt, l2_valid, l2_we, l2_src, busy, timeout_err;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] ic_cnt, dc_cnt, conflict_cnt;

  int passed = 0;
  int total  = 0;

  l2_req_arbiter #(.ADDR_W(AW), .CNT_W(CW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_gnt(dc_gnt),
    .l2_valid(l2_valid), .l2_addr(l2_addr), .l2_we(l2_we), .l2_src(l2_src),
    .l2_ready(l2_ready), .l2_done(l2_done), .busy(busy),
    .ic_cnt(ic_cnt), .dc_cnt(dc_cnt), .conflict_cnt(conflict_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req = 0; dc_req = 0; dc_we = 0; l2_ready = 0; l2_done = 0;
    ic_addr = '0; dc_addr = '0;
  endtask

  task automatic test_reset();
    logic [3*CW+AW+7:0] got;
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    got = {ic_gnt, dc_gnt, l2_valid, l2_we, l2_src, busy, timeout_err, 1'b0,
           l2_addr, ic_cnt, dc_cnt, conflict_cnt};
    total++;
    if (got !== '0) $display("FAIL reset_state got=%h exp=0", got);
    else passed++;
    rst_n = 1;
  endtask

  task automatic test_single_ic();
    test_reset();
    ic_req = 1; ic_addr = 26'h0ABCDE;
    tick();
    total++;
    if ({ic_gnt, dc_gnt, l2_valid, l2_src, l2_we, busy} !== 6'b101001 || l2_addr !== 26'h0ABCDE || ic_cnt !== 4'd1)
      $display("FAIL single_ic_grant gnt=%b/%b v=%b src=%b we=%b busy=%b addr=%h cnt=%0d exp 1/0 1 0 0 1 0abcde 1",
               ic_gnt, dc_gnt, l2_valid, l2_src, l2_we, busy, l2_addr, ic_cnt);
    else passed++;
    ic_req = 0;
    tick();
    total++;
    if (ic_gnt !== 1'b0 || l2_valid !== 1'b1)
      $display("FAIL single_ic_pulse gnt=%b valid=%b exp gnt=0 valid=1", ic_gnt, l2_valid);
    else passed++;
    l2_ready = 1; l2_done = 1;
    tick();
    total++;
    if (l2_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_ic_done valid=%b busy=%b exp 0 0", l2_valid, busy);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic ei, ed;
    test_reset();
    ic_req = 1; dc_req = 1; ic_addr = 26'h111; dc_addr = 26'h222;
    l2_ready = 1; l2_done = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      ei = (c == 1) || (c == 7);
      ed = (c == 4) || (c == 10);
      total++;
      if (ic_gnt !== ei || dc_gnt !== ed)
        $display("FAIL rr_cycle%0d ic_gnt=%b dc_gnt=%b exp %b %b", c, ic_gnt, dc_gnt, ei, ed);
      else passed++;
      if (c == 4) begin
        total++;
        if (l2_src !== 1'b1 || l2_addr !== 26'h222)
          $display("FAIL rr_dc_latch src=%b addr=%h exp 1 222", l2_src, l2_addr);
        else passed++;
      end
    end
    total++;
    if (ic_cnt !== 4'd2 || dc_cnt !== 4'd2 || conflict_cnt !== 4'd4)
      $display("FAIL rr_counts ic=%0d dc=%0d conf=%0d exp 2 2 4", ic_cnt, dc_cnt, conflict_cnt);
    else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_dc_write_stall();
    test_reset();
    dc_req = 1; dc_we = 1; dc_addr = 26'h3FFFFFF;
    tick();
    total++;
    if (dc_gnt !== 1'b1 || l2_valid !== 1'b1 || l2_we !== 1'b1 || l2_src !== 1'b1 || l2_addr !== 26'h3FFFFFF || dc_cnt !== 4'd1)
      $display("FAIL dcw_grant gnt=%b v=%b we=%b src=%b addr=%h cnt=%0d exp 1 1 1 1 3ffffff 1",
               dc_gnt, l2_valid, l2_we, l2_src, l2_addr, dc_cnt);
    else passed++;
    dc_req = 0; dc_we = 0; dc_addr = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (l2_valid !== 1'b1 || l2_addr !== 26'h3FFFFFF || l2_we !== 1'b1 || dc_gnt !== 1'b0)
        $display("FAIL dcw_hold%0d v=%b addr=%h we=%b gnt=%b exp 1 3ffffff 1 0", i, l2_valid, l2_addr, l2_we, dc_gnt);
      else passed++;
    end
    l2_ready = 1;
    tick();
    l2_ready = 0;
    total++;
    if (l2_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL dcw_wait v=%b busy=%b exp 0 1", l2_valid, busy);
    else passed++;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL dcw_busy busy=%b exp 1", busy);
    else passed++;
    l2_done = 1;
    tick();
    l2_done = 0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL dcw_done busy=%b terr=%b exp 0 0", busy, timeout_err);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    test_reset();
    // l2_done in the last allowed WAIT cycle wins over the timeout.
    ic_req = 1; ic_addr = 26'h55;
    tick();
    ic_req = 0; l2_ready = 1;
    tick();
    l2_ready = 0;
    repeat (3) tick();
    l2_done = 1;
    tick();
    l2_done = 0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL to_done_edge busy=%b terr=%b exp 0 0", busy, timeout_err);
    else passed++;
    ic_req = 1;
    tick();
    tick();
    ic_req = 0; l2_ready = 1;
    tick();
    l2_ready = 0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL to_before busy=%b terr=%b exp 1 0", busy, timeout_err);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1)
      $display("FAIL to_expire busy=%b terr=%b exp 0 1", busy, timeout_err);
    else passed++;
    ic_req = 1; ic_addr = 26'h123;
    tick();
    tick();
    total++;
    if (ic_gnt !== 1'b1 || l2_addr !== 26'h123 || timeout_err !== 1'b1 || ic_cnt !== 4'd3)
      $display("FAIL to_next gnt=%b addr=%h terr=%b cnt=%0d exp 1 123 1 3", ic_gnt, l2_addr, timeout_err, ic_cnt);
    else passed++;
    ic_req = 0; l2_ready = 1; l2_done = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    test_reset();
    ic_req = 1; ic_addr = 26'h77;
    tick();
    ic_req = 0; l2_ready = 1;
    tick();
    l2_ready = 0;
    tick();
    total++;
    if (busy !== 1'b1 || ic_cnt !== 4'd1)
      $display("FAIL mid_pre busy=%b cnt=%0d exp 1 1", busy, ic_cnt);
    else passed++;
    #2 rst_n = 0;
    #1;
    total++;
    if (busy !== 1'b0 || l2_valid !== 1'b0 || ic_cnt !== 4'd0 || l2_addr !== '0)
      $display("FAIL mid_async busy=%b v=%b cnt=%0d addr=%h exp 0 0 0 0", busy, l2_valid, ic_cnt, l2_addr);
    else passed++;
    tick();
    rst_n = 1;
    ic_req = 1; dc_req = 1;
    tick();
    total++;
    if (ic_gnt !== 1'b1 || dc_gnt !== 1'b0)
      $display("FAIL mid_first_conflict ic=%b dc=%b exp 1 0", ic_gnt, dc_gnt);
    else passed++;
    clear_inputs();
    l2_ready = 1; l2_done = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_saturation();
    int gnts;
    test_reset();
    gnts = 0;
    ic_req = 1; l2_ready = 1; l2_done = 1;
    for (int c = 0; c < 51; c++) begin
      tick();
      if (ic_gnt === 1'b1) gnts++;
    end
    total++;
    if (gnts !== 17) $display("FAIL sat_grants got=%0d exp 17", gnts);
    else passed++;
    total++;
    if (ic_cnt !== 4'hF || dc_cnt !== 4'd0 || conflict_cnt !== 4'd0)
      $display("FAIL sat_count ic=%h dc=%h conf=%h exp f 0 0", ic_cnt, dc_cnt, conflict_cnt);
    else passed++;
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_single_ic();
    test_round_robin();
    test_dc_write_stall();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
